// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read handshake, fetch-to-core valid/ready
// channel, branch redirect and halt status. The fetch unit uses the master side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;
    logic        if_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_ir, if_pc,
        input  if_ready, redirect, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_ir, if_pc,
        output if_ready, redirect, redirect_pc,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC-driven reads over req/ack into a prefetch queue feeding the core.
// Optional macro IFU_STALL_CNT_EN adds a saturating stall_count output.
//
// state  | meaning
// IDLE   | no read outstanding; issue when the queue has room
// WAIT   | read of fetch_pc outstanding; push data on ack
// SQUASH | read outstanding for a flushed path; drop data on ack
// HALT   | halt word fetched; no more reads until a redirect or reset
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0
) (
    input  logic clock,
    input  logic reset_n,
`ifdef IFU_STALL_CNT_EN
    output logic [15:0] stall_count,
`endif
    instr_fetch_unit_if.master bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, WAIT, SQUASH, HALT} state_t;

    state_t        state, state_nx;
    logic [15:0]   fetch_pc, fetch_pc_nx;
    logic [15:0]   target, target_nx;
    logic [15:0]   q_pc [DEPTH];
    logic [15:0]   q_ir [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
    logic [AW:0]   count, count_nx, count_ack;
    logic [15:0]   head_pc, head_ir, head_pc_nx, head_ir_nx;
    logic          halted_q;
    logic          pop, push, redir, halt_pop;
    logic [15:0]   redir_pc;

    assign pop        = (count != '0) & bus.if_ready;
    assign halt_pop   = pop & (head_ir == HALT_WORD);
    // Once the halt word has been taken by the core, redirects no longer restart fetch.
    assign redir      = bus.redirect & ~halted_q & ~halt_pop;
    assign redir_pc   = bus.redirect_pc & 16'hFFFE;
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign count_ack  = count + 1'b1 - (AW+1)'(pop);

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        target_nx   = target;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (redir)             fetch_pc_nx = redir_pc;
                else if (count < FULL) state_nx    = WAIT;
            end
            WAIT: begin
                if (redir) begin
                    if (bus.imem_ack) begin
                        state_nx    = IDLE;
                        fetch_pc_nx = redir_pc;
                    end else begin
                        state_nx  = SQUASH;
                        target_nx = redir_pc;
                    end
                end else if (bus.imem_ack) begin
                    push        = 1'b1;
                    fetch_pc_nx = fetch_pc + 16'd2;
                    if (bus.imem_rdata == HALT_WORD) state_nx = HALT;
                    else if (count_ack < FULL)       state_nx = WAIT;
                    else                             state_nx = IDLE;
                end
            end
            SQUASH: begin
                if (bus.imem_ack) begin
                    state_nx    = IDLE;
                    fetch_pc_nx = redir ? redir_pc : target;
                end else if (redir) begin
                    target_nx = redir_pc;
                end
            end
            HALT: begin
                if (redir) begin
                    state_nx    = IDLE;
                    fetch_pc_nx = redir_pc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            target   <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            target   <= target_nx;
        end
    end

    // Head registers load whichever entry becomes the head; they hold when the queue drains.
    always_comb begin
        count_nx   = redir ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
        head_pc_nx = head_pc;
        head_ir_nx = head_ir;
        if (!redir) begin
            if (pop && count > (AW+1)'(1)) begin
                head_pc_nx = q_pc[rd_ptr_inc];
                head_ir_nx = q_ir[rd_ptr_inc];
            end else if (push && (count == '0 || (pop && count == (AW+1)'(1)))) begin
                head_pc_nx = fetch_pc;
                head_ir_nx = bus.imem_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            head_pc  <= '0;
            head_ir  <= '0;
            halted_q <= 1'b0;
        end else begin
            count   <= count_nx;
            head_pc <= head_pc_nx;
            head_ir <= head_ir_nx;
            if (redir) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr_inc;
            end
            if (halt_pop) halted_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_pc[wr_ptr] <= fetch_pc;
            q_ir[wr_ptr] <= bus.imem_rdata;
        end
    end

`ifdef IFU_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (count == '0 && !halted_q && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

    assign bus.imem_req  = (state == WAIT) || (state == SQUASH);
    assign bus.imem_addr = fetch_pc;
    assign bus.if_valid  = (count != '0);
    assign bus.if_ir     = head_ir;
    assign bus.if_pc     = head_pc;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: latency-programmable memory model, pop/request
// logging monitor, and hand-computed expectations for fill, drain, redirect, halt and reset.
module tb_instr_fetch_unit;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    instr_fetch_unit_if bus();
`ifdef IFU_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
`ifdef IFU_STALL_CNT_EN
        .stall_count (stall_count),
`endif
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: acks `lat` cycles after a request starts (0 = same cycle).
    logic [15:0] mem [256];
    int lat  = 1;
    int wcnt = 0;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0;
        forever begin
            @(negedge clock);
            if (!reset_n || !bus.imem_req) begin
                bus.imem_ack = 1'b0;
                wcnt = 0;
            end else begin
                if (bus.imem_ack) wcnt = 0;
                if (wcnt >= lat) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem[bus.imem_addr[8:1]];
                end else begin
                    bus.imem_ack = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    // Monitor samples 3ns after each negedge; tests sample at +4.
    logic [15:0] pop_pc [$];
    logic [15:0] pop_ir [$];
    int          pop_cyc [$];
    logic [15:0] req_addr [$];
    int          cyc = 0;
    int          halt_cyc = -1;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_halted = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    initial forever begin
        @(negedge clock);
        #3;
        cyc++;
        if (!reset_n) begin
            prev_req    = 1'b0;
            prev_ack    = 1'b0;
            prev_halted = 1'b0;
        end else begin
            if (bus.if_valid && bus.if_ready) begin
                pop_pc.push_back(bus.if_pc);
                pop_ir.push_back(bus.if_ir);
                pop_cyc.push_back(cyc);
            end
            if (bus.halted && !prev_halted) halt_cyc = cyc;
            if (bus.imem_req) begin
                if (!prev_req || prev_ack) req_addr.push_back(bus.imem_addr);
                else chk("addr_stable", 32'(bus.imem_addr), 32'(prev_addr));
            end
            prev_req    = bus.imem_req;
            prev_ack    = bus.imem_ack;
            prev_addr   = bus.imem_addr;
            prev_halted = bus.halted;
        end
    end

    task automatic sample();
        @(negedge clock);
        #4;
    endtask

    task automatic reset_dut(input int l, input logic rdy);
        @(negedge clock);
        reset_n         = 1'b0;
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0;
        repeat (2) @(negedge clock);
        pop_pc.delete();
        pop_ir.delete();
        pop_cyc.delete();
        req_addr.delete();
        halt_cyc     = -1;
        lat          = l;
        bus.if_ready = rdy;
        reset_n      = 1'b1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (pop_pc.size() < n && k < budget) begin
            sample();
            k++;
        end
        chk(tag, 32'(pop_pc.size() >= n), 32'd1);
    endtask

    initial begin
        int k;
        int n0;
        int np;
        reset_n         = 1'b1;
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0;
        #1 reset_n = 1'b0;
        #2;
        // Reset values
        chk("rst_req",    32'(bus.imem_req),  32'd0);
        chk("rst_addr",   32'(bus.imem_addr), 32'h0);
        chk("rst_valid",  32'(bus.if_valid),  32'd0);
        chk("rst_ir",     32'(bus.if_ir),     32'h0);
        chk("rst_pc",     32'(bus.if_pc),     32'h0);
        chk("rst_halted", 32'(bus.halted),    32'd0);
`ifdef IFU_STALL_CNT_EN
        chk("rst_stall",  32'(stall_count),   32'd0);
`endif

        // T1: 1-cycle memory, core always ready
        reset_dut(1, 1'b1);
        wait_pops(6, 60, "t1_timeout");
        if (pop_pc.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("t1_pc", 32'(pop_pc[i]), 32'(2 * i));
                chk("t1_ir", 32'(pop_ir[i]), 32'(16'hA000 + 16'(i)));
            end
            chk("t1_rate", 32'(pop_cyc[4] - pop_cyc[3]), 32'd2);
        end

        // T2: zero-wait memory, core stalled -> queue fills to 4
        reset_dut(0, 1'b0);
        repeat (12) sample();
        chk("t2_nreq",     32'(req_addr.size()), 32'd4);
        chk("t2_req_idle", 32'(bus.imem_req),    32'd0);
        chk("t2_valid",    32'(bus.if_valid),    32'd1);
        chk("t2_head_pc",  32'(bus.if_pc),       32'h0);
        @(negedge clock);
        bus.if_ready = 1'b1;
        wait_pops(5, 30, "t2_timeout");
        if (pop_pc.size() >= 5 && req_addr.size() >= 5) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_pc", 32'(pop_pc[i]), 32'(2 * i));
                chk("t2_ir", 32'(pop_ir[i]), 32'(16'hA000 + 16'(i)));
            end
            chk("t2_resume_addr", 32'(req_addr[4]), 32'h8);
            chk("t2_resume_pop",  32'(pop_pc[4]),   32'h8);
        end

        // T3: redirect while pc 4 read waits 3 cycles
        reset_dut(3, 1'b1);
        k = 0;
        while (req_addr.size() < 3 && k < 40) begin
            sample();
            k++;
        end
        chk("t3_reach", 32'(req_addr.size() >= 3), 32'd1);
        if (req_addr.size() >= 3) chk("t3_third_req", 32'(req_addr[2]), 32'h4);
        @(negedge clock);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0021;
        @(negedge clock);
        bus.redirect    = 1'b0;
        #4;
        chk("t3_sq_req",   32'(bus.imem_req),  32'd1);
        chk("t3_sq_addr",  32'(bus.imem_addr), 32'h4);
        chk("t3_sq_valid", 32'(bus.if_valid),  32'd0);
        n0 = req_addr.size();
        np = pop_pc.size();
        sample();
        chk("t3_hold_addr",  32'(bus.imem_addr), 32'h4);
        chk("t3_hold_valid", 32'(bus.if_valid),  32'd0);
        k = 0;
        while (req_addr.size() <= n0 && k < 20) begin
            sample();
            k++;
        end
        chk("t3_newreq_seen", 32'(req_addr.size() > n0), 32'd1);
        if (req_addr.size() > n0) chk("t3_new_addr", 32'(req_addr[n0]), 32'h20);
        wait_pops(np + 1, 20, "t3_pop_timeout");
        if (pop_pc.size() > np) begin
            chk("t3_pop_pc", 32'(pop_pc[np]), 32'h20);
            chk("t3_pop_ir", 32'(pop_ir[np]), 32'hA010);
        end

        // T4: halt word at pc 10
        mem[5] = 16'hFFFF;
        reset_dut(1, 1'b1);
        k = 0;
        while (!bus.halted && k < 80) begin
            sample();
            k++;
        end
        chk("t4_halted", 32'(bus.halted), 32'd1);
        chk("t4_nreq",   32'(req_addr.size()), 32'd6);
        if (req_addr.size() >= 1) chk("t4_last_req", 32'(req_addr[req_addr.size()-1]), 32'hA);
        if (pop_pc.size() >= 6) begin
            chk("t4_halt_pc",     32'(pop_pc[5]), 32'hA);
            chk("t4_halt_ir",     32'(pop_ir[5]), 32'hFFFF);
            chk("t4_halt_timing", 32'(halt_cyc - pop_cyc[5]), 32'd1);
        end
        @(negedge clock);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        @(negedge clock);
        bus.redirect    = 1'b0;
        repeat (8) sample();
        chk("t4_no_req_after", 32'(req_addr.size()), 32'd6);
        chk("t4_req_low",      32'(bus.imem_req),    32'd0);
        chk("t4_still_halted", 32'(bus.halted),      32'd1);
        mem[5] = 16'hA005;

        // T5: redirect coincident with ack and pop
        reset_dut(0, 1'b1);
        wait_pops(3, 20, "t5_timeout");
        @(negedge clock);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0031;
        #4;
        chk("t5_ack_same",   32'(bus.imem_ack), 32'd1);
        chk("t5_valid_same", 32'(bus.if_valid), 32'd1);
        @(negedge clock);
        bus.redirect = 1'b0;
        #4;
        chk("t5_valid_off", 32'(bus.if_valid), 32'd0);
        wait_pops(5, 20, "t5_pop_timeout");
        if (pop_pc.size() >= 5 && req_addr.size() >= 6) begin
            chk("t5_consumed",  32'(pop_pc[3]),   32'h6);
            chk("t5_drop_addr", 32'(req_addr[4]), 32'h8);
            chk("t5_new_addr",  32'(req_addr[5]), 32'h30);
            chk("t5_new_pc",    32'(pop_pc[4]),   32'h30);
            chk("t5_new_ir",    32'(pop_ir[4]),   32'hA018);
        end

        // T6: reset mid-WAIT
        reset_dut(5, 1'b1);
        sample();
        chk("t6_req_wait",  32'(bus.imem_req),  32'd1);
        chk("t6_addr_wait", 32'(bus.imem_addr), 32'h0);
`ifdef IFU_STALL_CNT_EN
        chk("t6_stall_1", 32'(stall_count), 32'd1);
`endif
        sample();
`ifdef IFU_STALL_CNT_EN
        chk("t6_stall_2", 32'(stall_count), 32'd2);
`endif
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(bus.imem_req), 32'd0);
`ifdef IFU_STALL_CNT_EN
        chk("t6_stall_rst", 32'(stall_count), 32'd0);
`endif
        reset_dut(5, 1'b1);
        sample();
        chk("t6_restart_req",  32'(bus.imem_req),  32'd1);
        chk("t6_restart_addr", 32'(bus.imem_addr), 32'h0);
        wait_pops(1, 30, "t6_timeout");
        if (pop_pc.size() >= 1) begin
            chk("t6_pop_pc", 32'(pop_pc[0]), 32'h0);
            chk("t6_pop_ir", 32'(pop_ir[0]), 32'hA000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
